// File: rtl/sar_search8.sv
// -----------------------------------------------------------------------------
// sar_search8 -- successive-approximation search engine.
//
// Drives the b operand (guess) of an external combinational magnitude
// comparator whose a operand is an unknown target, and reads back the
// comparator's MORE/LESS flags. A search recovers the target in WIDTH trial
// compares (one per bit, MSB first) plus one verifying compare.
//
// Ports:
//   clk     in   1              rising-edge clock
//   rst_n   in   1              asynchronous active-low reset
//   start   in   1              begin a search; honoured only in IDLE and not
//                               in the cycle where done is high
//   guess   out  WIDTH          registered b operand for the comparator
//   more    in   1              comparator flag: target > guess
//   less    in   1              comparator flag: target < guess
//   busy    out  1              high while a search is in progress
//   done    out  1              one-cycle pulse at the end of a search
//   found   out  1              with done: result confirmed equal to target
//   err     out  1              with done: comparator reported more=less=1
//   result  out  WIDTH          recovered value, held until the next done
//   steps   out  clog2(WIDTH+2) compares used by the last search
//
// Optional feature (macro SAR_EARLY_EXIT_EN): when defined, a trial compare
// that reports equality ends the search immediately and skips VERIFY.
// Without it every search takes WIDTH+1 compares.
// -----------------------------------------------------------------------------
module sar_search8 #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [WIDTH-1:0]             guess,
  input  logic                         more,
  input  logic                         less,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic                         err,
  output logic [WIDTH-1:0]             result,
  output logic [$clog2(WIDTH+2)-1:0]   steps
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(WIDTH + 2);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
    VERIFY = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] guess_q;
  logic [WIDTH-1:0] result_q;
  logic [KW-1:0]    k_q;
  logic [SW-1:0]    cnt_q;
  logic [SW-1:0]    steps_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic             err_q;

  // Next-state helpers for the bit under trial.
  logic [WIDTH-1:0] acc_d;    // accumulator with bit k resolved
  logic [WIDTH-1:0] trial_d;  // next guess: resolved bits plus the next trial bit
  logic [SW-1:0]    cnt_d;
  logic             cmp_bad;  // comparator claims both greater and smaller

  // Bit k keeps its trial 1 unless the target is strictly below the guess;
  // equality therefore keeps the bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_acc
    localparam logic [KW-1:0] BIT_IDX = KW'(gi);
    assign acc_d[gi] = (k_q == BIT_IDX) ? ~less : acc_q[gi];
  end

  // Only meaningful while k_q > 0; at k_q == 0 the guess takes acc_d directly.
  assign trial_d = acc_d | (ONE << (k_q - 1'b1));
  assign cnt_d   = cnt_q + SW'(1);
  assign cmp_bad = more & less;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      guess_q  <= '0;
      result_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_q high means we entered IDLE on the previous edge; a start
          // arriving in that cycle is deliberately dropped.
          if (start && !done_q) begin
            acc_q   <= '0;
            k_q     <= KW'(WIDTH - 1);
            guess_q <= MSB;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= TEST;
          end
        end

        TEST: begin
          if (cmp_bad) begin
            err_q    <= 1'b1;
            found_q  <= 1'b0;
            result_q <= guess_q;
            steps_q  <= cnt_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
`ifdef SAR_EARLY_EXIT_EN
          end else if (!more && !less) begin
            result_q <= guess_q;
            found_q  <= 1'b1;
            steps_q  <= cnt_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
`endif
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (k_q != '0) begin
              k_q     <= k_q - 1'b1;
              guess_q <= trial_d;
            end else begin
              guess_q <= acc_d;
              state_q <= VERIFY;
            end
          end
        end

        VERIFY: begin
          // Catches a target that moved during TEST: the converged value is
          // reported, but found stays low.
          if (cmp_bad) begin
            err_q   <= 1'b1;
            found_q <= 1'b0;
          end else begin
            found_q <= ~more & ~less;
          end
          result_q <= guess_q;
          cnt_q    <= cnt_d;
          steps_q  <= cnt_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search8.sv
// -----------------------------------------------------------------------------
// tb_sar_search8 -- randomized scoreboard bench for sar_search8.
// The stimulus process issues searches against a modelled comparator and
// pushes the expected completion record; an independent monitor pops and
// compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_sar_search8;

  localparam int W = 8;
`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] guess;
  logic         more, less;
  logic         busy, done, found, err;
  logic [W-1:0] result;
  logic [3:0]   steps;

  int   target = 0;
  logic force_err = 1'b0;

  // Comparator model.
  assign more = force_err | (target > int'(guess));
  assign less = force_err | (target < int'(guess));

  sar_search8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
    .more(more), .less(less), .busy(busy), .done(done),
    .found(found), .err(err), .result(result), .steps(steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    int result;
    int found;
    int err;
    int steps;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   walk_g [0:W];  // expected guess after each clock edge of the search

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: binary search over bit positions, MSB first. A candidate bit
  // stays set when the target (as seen at that compare) is >= the candidate.
  // Compare number n (1-based) sees the new target once n > flip_after.
  task automatic model(input int old_t, input int flip_after, input int new_t,
                       input int err_at, output exp_t e);
    int  acc, cand, tn;
    bit  fin;
    acc = 0; fin = 0;
    e.result = 0; e.found = 0; e.err = 0; e.steps = 0;
    for (int s = 1; s <= W && !fin; s++) begin
      cand = acc + (1 << (W - s));
      walk_g[s-1] = cand;
      tn = (s > flip_after) ? new_t : old_t;
      if (err_at == s) begin
        e.err = 1; e.result = cand; e.steps = s; fin = 1;
      end else if (EARLY && tn == cand) begin
        e.found = 1; e.result = cand; e.steps = s; fin = 1;
      end else if (tn >= cand) begin
        acc = cand;
      end
    end
    if (!fin) begin
      walk_g[W] = acc;
      tn = (W + 1 > flip_after) ? new_t : old_t;
      e.result = acc;
      e.steps  = W + 1;
      if (err_at == W + 1) e.err = 1;
      else e.found = (tn == acc) ? 1 : 0;
    end
  endtask

  // mode 0: plain, 1: force more=less=1 on compare 'param',
  // 2: switch target to new_t after 'param' compares, 3: start pokes while busy/at done.
  task automatic run_search(input int tgt, input int mode, input int param, input int new_t);
    exp_t e;
    int   guard, lat;
    model(tgt, (mode == 2) ? param : 99, new_t, (mode == 1) ? param : 99, e);
    guard = 0;
    while ((busy || done) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("idle_wait", (guard < 50), 1);
    target = tgt;
    start  = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("err_clr_on_start", err, 0);
    chk("guess0", guess, walk_g[0]);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (mode == 1 && c == param) force_err = 1'b1;
      if (mode == 3 && c == 3) start = 1'b1;
      if (mode == 3 && c == 4) start = 1'b0;
      @(posedge clk); #1;
      if (mode == 2 && c == param) target = new_t;
      if (done) begin
        lat = c;
        break;
      end
      if (c <= W) chk("guess_walk", guess, walk_g[c]);
    end
    force_err = 1'b0;
    start     = 1'b0;
    chk("latency", lat, e.steps);
    $display("search tgt=%02h mode=%0d param=%0d new=%02h -> result=%02h found=%0b err=%0b steps=%0d lat=%0d",
             tgt, mode, param, new_t, result, found, err, steps, lat);
    if (mode == 3) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_on_done_ignored", busy, 0);
    end
  endtask

  // Monitor: one pop per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.result);
        chk("found",  found,  e.found);
        chk("err",    err,    e.err);
        chk("steps",  steps,  e.steps);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int t, m, p, nt;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {guess, result, steps, busy, done, found, err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_guess_hold", guess, 0);

    // Directed cases.
    run_search(8'hA5, 0, 0, 0);
    run_search(8'h00, 0, 0, 0);
    run_search(8'hFF, 0, 0, 0);
    run_search(8'h5B, 1, 3, 0);
    run_search(8'h5B, 0, 0, 0);          // err/found cleared by the next start
    run_search(8'h3C, 2, 4, 8'hC3);
    run_search(8'h6E, 3, 0, 0);
    run_search(8'h80, 0, 0, 0);
    run_search(8'h01, 0, 0, 0);
    run_search(8'h77, 1, EARLY ? 8 : 9, 0);

    // Reset in the middle of a search: no done, outputs back to zero.
    target = 8'h9A;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {guess, result, steps, busy, done, found, err}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized searches.
    for (int i = 0; i < 40; i++) begin
      t  = $urandom_range(0, 255);
      m  = $urandom_range(0, 9);
      nt = $urandom_range(0, 255);
      if (m <= 4) run_search(t, 0, 0, 0);
      else if (m <= 6) begin
        p = $urandom_range(1, W + 1);
        run_search(t, 1, p, 0);
      end else if (m <= 8) begin
        p = $urandom_range(1, W - 1);
        run_search(t, 2, p, nt);
      end else run_search(t, 3, 0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
